// File: rtl/parking_controller.sv
// Six-bay car park sequencer: lowest-free-bay allocation on entry,
// per-bay entry timestamps and iterative hourly fee on exit.
module parking_controller #(
    parameter int NUM_SLOTS = 6,
    parameter int TIME_W    = 11,
    parameter int FEE_W     = 11,
    parameter int RATE      = 10,
    parameter int MIN_HOUR  = 60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TIME_W-1:0]    timer,
    input  logic                 in_req,
    input  logic                 out_req,
    input  logic [3:0]           out_slot,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [3:0]           slot_id,
    output logic [FEE_W-1:0]     fee,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic                 full
);
    localparam int AW = TIME_W + 4;

    typedef enum logic [2:0] {
        IDLE,
        ALLOC,
        CAP,
        DIV,
        DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [TIME_W-1:0] stamp [NUM_SLOTS];
    logic [AW-1:0]     rem;
    logic [AW-1:0]     hrs;
    logic [3:0]        sel;
    logic [3:0]        free_id;
    logic              slot_ok;
    logic [TIME_W-1:0] sel_stamp;
    logic [AW-1:0]     u;
    logic [AW-1:0]     fee_raw;
    logic [FEE_W-1:0]  fee_sat;
    logic              hour_left;

    assign full      = &occupied;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign hour_left = (rem >= AW'(MIN_HOUR));

    // Scan from the top so the lowest free bay wins.
    always_comb begin
        free_id = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occupied[i]) free_id = 4'(i + 1);
        end
    end

    always_comb begin
        slot_ok   = 1'b0;
        sel_stamp = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (sel == 4'(i + 1)) begin
                slot_ok   = occupied[i];
                sel_stamp = stamp[i];
            end
        end
    end

    // Elapsed minutes modulo the timer width, so a wrapped timer is handled.
    assign u = AW'(TIME_W'(timer - sel_stamp));

    always_comb begin
        fee_raw = AW'(RATE) * (hrs + AW'(rem != '0));
        fee_sat = (fee_raw > AW'({FEE_W{1'b1}})) ? '1 : FEE_W'(fee_raw);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (out_req)     state_n = CAP;
                else if (in_req) state_n = ALLOC;
            end
            ALLOC: state_n = DONE;
            CAP:   state_n = slot_ok ? DIV : DONE;
            DIV:   state_n = hour_left ? DIV : DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            slot_id  <= '0;
            fee      <= '0;
            occupied <= '0;
            rem      <= '0;
            hrs      <= '0;
            sel      <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) stamp[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (out_req) sel <= out_slot;
                end
                ALLOC: begin
                    fee <= '0;
                    if (full) begin
                        err     <= 1'b1;
                        slot_id <= '0;
                    end else begin
                        err     <= 1'b0;
                        slot_id <= free_id;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (free_id == 4'(i + 1)) begin
                                stamp[i]    <= timer;
                                occupied[i] <= 1'b1;
                            end
                        end
                    end
                end
                CAP: begin
                    if (!slot_ok) begin
                        err     <= 1'b1;
                        slot_id <= '0;
                        fee     <= '0;
                    end else begin
                        rem <= u;
                        hrs <= '0;
                    end
                end
                DIV: begin
                    if (hour_left) begin
                        rem <= rem - AW'(MIN_HOUR);
                        hrs <= hrs + 1'b1;
                    end else begin
                        fee     <= fee_sat;
                        slot_id <= sel;
                        err     <= 1'b0;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (sel == 4'(i + 1)) occupied[i] <= 1'b0;
                        end
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_parking_controller.sv
// Scoreboard bench for parking_controller: directed cases then
// random entry/exit traffic against an arithmetic reference model.
module tb_parking_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] timer = '0;
    logic        in_req = 1'b0;
    logic        out_req = 1'b0;
    logic [3:0]  out_slot = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  slot_id;
    logic [10:0] fee;
    logic [5:0]  occupied;
    logic        full;

    parking_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .timer    (timer),
        .in_req   (in_req),
        .out_req  (out_req),
        .out_slot (out_slot),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .slot_id  (slot_id),
        .fee      (fee),
        .occupied (occupied),
        .full     (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [3:0]  slot;
        logic [10:0] fee;
        logic [5:0]  occ;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   occ_m [1:6];
    int   stamp_m [1:6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [5:0] occ_vec();
        logic [5:0] v;
        for (int i = 1; i <= 6; i++) v[i-1] = occ_m[i];
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("err", int'(err), int'(e.err));
                chk("slot_id", int'(slot_id), int'(e.slot));
                chk("fee", int'(fee), int'(e.fee));
                chk("occupied", int'(occupied), int'(e.occ));
                chk("full", int'(full), int'(&e.occ));
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) chk("timeout", 1, 0);
    endtask

    // Issue one request; the expected result is computed from plain rules.
    task automatic issue(bit i, bit o, int s);
        int   smp;
        exp_t e;
        wait_idle();
        in_req   = i;
        out_req  = o;
        out_slot = 4'(s);
        @(posedge clk);
        #1;
        smp     = cyc;
        in_req  = 1'b0;
        out_req = 1'b0;
        e.err   = 1'b0;
        e.slot  = '0;
        e.fee   = '0;
        if (o) begin
            if (s >= 1 && s <= 6 && occ_m[s]) begin
                int u;
                int f;
                u = (int'(timer) - stamp_m[s] + 2048) % 2048;
                f = 10 * ((u + 59) / 60);
                if (f > 2047) f = 2047;
                occ_m[s] = 1'b0;
                e.slot   = 4'(s);
                e.fee    = 11'(f);
                e.cyc    = smp + u / 60 + 2;
            end else begin
                e.err = 1'b1;
                e.cyc = smp + 1;
            end
        end else if (i) begin
            int k = 0;
            for (int b = 6; b >= 1; b--) if (!occ_m[b]) k = b;
            if (k == 0) begin
                e.err = 1'b1;
            end else begin
                occ_m[k]   = 1'b1;
                stamp_m[k] = int'(timer);
                e.slot     = 4'(k);
            end
            e.cyc = smp + 1;
        end
        e.occ = occ_vec();
        if (i || o) q.push_back(e);
        wait_idle();
    endtask

    task automatic set_time(int t);
        timer = 11'(t % 2048);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int b = 1; b <= 6; b++) begin
            occ_m[b]   = 1'b0;
            stamp_m[b] = 0;
        end
        q.delete();
        #7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_slot", int'(slot_id), 0);
        chk("rst_fee", int'(fee), 0);
        chk("rst_occ", int'(occupied), 0);

        for (int n = 0; n < 7; n++) begin
            set_time(10 + n);
            issue(1, 0, 0);
        end
        chk("full_after_six", int'(full), 1);

        issue(0, 1, 3);
        set_time(100);
        issue(1, 0, 0);
        set_time(161);
        issue(0, 1, 3);

        set_time(200);
        issue(1, 0, 0);
        set_time(320);
        issue(0, 1, 3);
        set_time(400);
        issue(1, 0, 0);
        issue(0, 1, 3);
        set_time(500);
        issue(1, 0, 0);
        set_time(559);
        issue(0, 1, 3);
        set_time(2040);
        issue(1, 0, 0);
        set_time(20);
        issue(0, 1, 3);

        issue(1, 0, 0);
        chk("full_again", int'(full), 1);
        set_time(90);
        issue(1, 1, 2);
        issue(1, 0, 0);

        issue(0, 1, 2);
        issue(0, 1, 2);
        issue(0, 1, 0);
        issue(0, 1, 7);

        set_time(1600);
        wait_idle();
        out_req  = 1'b1;
        out_slot = 4'd1;
        @(posedge clk);
        #1;
        out_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("busy_in_div", int'(busy), 1);
        do_reset();
        chk("abort_occ", int'(occupied), 0);
        chk("abort_busy", int'(busy), 0);
        issue(1, 0, 0);

        for (int n = 0; n < 120; n++) begin
            int r;
            set_time(int'(timer) + int'($urandom_range(0, 400)));
            r = int'($urandom_range(0, 9));
            if (r < 4)      issue(1, 0, 0);
            else if (r < 7) issue(0, 1, int'($urandom_range(1, 6)));
            else if (r < 8) issue(0, 1, int'($urandom_range(0, 15)));
            else            issue(1, 1, int'($urandom_range(0, 7)));
        end

        wait_idle();
        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
